// File: rtl/tx_result_fifo_if.sv
// tx_result_fifo_if: write/launch/status bundle between INTF, the result FIFO and UART_TX
interface tx_result_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 2
);
  logic                  i_wr_signal;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  i_tx_done;
  logic                  o_tx_signal;
  logic [DATA_WIDTH-1:0] o_tx_data;
  logic                  o_empty;
  logic                  o_full;
  logic [DEPTH_LOG2:0]   o_count;
  logic                  o_overflow;
  modport master (
    output i_wr_signal, i_wr_data, i_tx_done,
    input  o_tx_signal, o_tx_data, o_empty, o_full, o_count, o_overflow
  );
  modport slave (
    input  i_wr_signal, i_wr_data, i_tx_done,
    output o_tx_signal, o_tx_data, o_empty, o_full, o_count, o_overflow
  );
endinterface

// File: rtl/tx_result_fifo.sv
// tx_result_fifo: queues result bytes and launches them one at a time into UART_TX
module tx_result_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input logic             i_clock,
  input logic             i_reset,
  tx_result_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;
  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]     count;
  logic                    pop, push;
  // a full FIFO still accepts a write when the same edge frees a slot
  assign pop  = state == IDLE && count != '0;
  assign push = bus.i_wr_signal && (count != FULL_COUNT || pop);
  assign bus.o_count = count;
  assign bus.o_empty = count == '0;
  assign bus.o_full  = count == FULL_COUNT;
  always_ff @(posedge i_clock)
    if (push) mem[wr_ptr] <= bus.i_wr_data;
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      bus.o_tx_signal <= 1'b0;
      bus.o_tx_data   <= '0;
      bus.o_overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (bus.i_wr_signal && !push) bus.o_overflow <= 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      case (state)
        IDLE: if (pop) begin
          bus.o_tx_data   <= mem[rd_ptr];
          bus.o_tx_signal <= 1'b1;
          rd_ptr          <= rd_ptr + 1'b1;
          state           <= LAUNCH;
        end
        LAUNCH: begin
          bus.o_tx_signal <= 1'b0;
          state           <= WAIT_DONE;
        end
        WAIT_DONE: if (bus.i_tx_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tx_result_fifo.sv
// tb_tx_result_fifo: per-cycle vector table plus an asynchronous reset sequence
module tb_tx_result_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  tx_result_fifo_if #(.DATA_WIDTH(8), .DEPTH_LOG2(2)) bus ();
  tx_result_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(2)) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus(bus)
  );
  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       done;
    logic       sig;
    logic [7:0] txd;
    int         cnt;
    logic       ovf;
  } vec_t;
  vec_t vec[$];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic add(input logic wr, input logic [7:0] d, input logic done,
                     input logic sig, input logic [7:0] txd, input int cnt, input logic ovf);
    vec.push_back('{wr, d, done, sig, txd, cnt, ovf});
  endtask
  task automatic check_out(input string tag, input logic sig, input logic [7:0] txd,
                           input int cnt, input logic ovf);
    chk({tag, " sig"}, 32'(bus.o_tx_signal), 32'(sig));
    chk({tag, " txd"}, 32'(bus.o_tx_data), 32'(txd));
    chk({tag, " cnt"}, 32'(bus.o_count), 32'(cnt));
    chk({tag, " empty"}, 32'(bus.o_empty), 32'(cnt == 0));
    chk({tag, " full"}, 32'(bus.o_full), 32'(cnt == 4));
    chk({tag, " ovf"}, 32'(bus.o_overflow), 32'(ovf));
  endtask
  task automatic run(input string tag);
    for (int i = 0; i < vec.size(); i++) begin
      bus.i_wr_signal = vec[i].wr;
      bus.i_wr_data   = vec[i].d;
      bus.i_tx_done   = vec[i].done;
      tick();
      check_out($sformatf("%s[%0d]", tag, i), vec[i].sig, vec[i].txd, vec[i].cnt, vec[i].ovf);
    end
    bus.i_wr_signal = 1'b0;
    bus.i_wr_data   = 8'h00;
    bus.i_tx_done   = 1'b0;
    vec.delete();
  endtask
  initial begin
    bus.i_wr_signal = 1'b0;
    bus.i_wr_data   = 8'h00;
    bus.i_tx_done   = 1'b0;
    tick();
    tick();
    check_out("reset", 1'b0, 8'h00, 0, 1'b0);
    rst_n = 1'b1;
    // single byte: launch one edge after the write, then wait for done
    add(1,8'h06,0, 0,8'h00,1,0); add(0,0,0, 1,8'h06,0,0); add(0,0,0, 0,8'h06,0,0);
    add(0,0,0, 0,8'h06,0,0);     add(0,0,1, 0,8'h06,0,0); add(0,0,0, 0,8'h06,0,0);
    add(0,0,0, 0,8'h06,0,0);
    run("single");
    add(1,8'h01,0, 0,8'h06,1,0); add(1,8'h02,0, 1,8'h01,1,0); add(1,8'h03,0, 0,8'h01,2,0);
    add(1,8'h04,0, 0,8'h01,3,0); add(0,0,0, 0,8'h01,3,0);     add(0,0,1, 0,8'h01,3,0);
    add(0,0,0, 1,8'h02,2,0);     add(0,0,0, 0,8'h02,2,0);     add(0,0,1, 0,8'h02,2,0);
    add(0,0,0, 1,8'h03,1,0);     add(0,0,0, 0,8'h03,1,0);     add(0,0,1, 0,8'h03,1,0);
    add(0,0,0, 1,8'h04,0,0);     add(0,0,0, 0,8'h04,0,0);     add(0,0,1, 0,8'h04,0,0);
    add(0,0,0, 0,8'h04,0,0);
    run("burst");
    // fill while busy, then a dropped write that must never be launched
    add(1,8'h10,0, 0,8'h04,1,0); add(1,8'h11,0, 1,8'h10,1,0); add(1,8'h12,0, 0,8'h10,2,0);
    add(1,8'h13,0, 0,8'h10,3,0); add(1,8'h14,0, 0,8'h10,4,0); add(1,8'hAA,0, 0,8'h10,4,1);
    add(0,0,1, 0,8'h10,4,1);     add(0,0,0, 1,8'h11,3,1);     add(0,0,0, 0,8'h11,3,1);
    add(0,0,1, 0,8'h11,3,1);     add(0,0,0, 1,8'h12,2,1);     add(0,0,0, 0,8'h12,2,1);
    add(0,0,1, 0,8'h12,2,1);     add(0,0,0, 1,8'h13,1,1);     add(0,0,0, 0,8'h13,1,1);
    add(0,0,1, 0,8'h13,1,1);     add(0,0,0, 1,8'h14,0,1);     add(0,0,0, 0,8'h14,0,1);
    add(0,0,1, 0,8'h14,0,1);     add(0,0,0, 0,8'h14,0,1);     add(0,0,0, 0,8'h14,0,1);
    run("overflow");
    add(1,8'h30,0, 0,8'h14,1,1); add(1,8'h31,0, 1,8'h30,1,1); add(1,8'h32,0, 0,8'h30,2,1);
    add(0,0,0, 0,8'h30,2,1);
    run("prereset");
    // asynchronous reset between edges while waiting on a frame with 2 queued
    rst_n = 1'b0;
    #2;
    check_out("async", 1'b0, 8'h00, 0, 1'b0);
    #1;
    rst_n = 1'b1;
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
    check_out("postrst0", 1'b0, 8'h00, 0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check_out($sformatf("postrst%0d", i), 1'b0, 8'h00, 0, 1'b0);
    end
    // full FIFO accepts 0x55 on the popping edge; pointers wrap past 3
    add(1,8'h20,0, 0,8'h00,1,0); add(1,8'h21,0, 1,8'h20,1,0); add(1,8'h22,0, 0,8'h20,2,0);
    add(1,8'h23,0, 0,8'h20,3,0); add(1,8'h24,0, 0,8'h20,4,0); add(0,0,1, 0,8'h20,4,0);
    add(1,8'h55,0, 1,8'h21,4,0); add(0,0,0, 0,8'h21,4,0);     add(0,0,1, 0,8'h21,4,0);
    add(0,0,0, 1,8'h22,3,0);     add(0,0,0, 0,8'h22,3,0);     add(0,0,1, 0,8'h22,3,0);
    add(0,0,0, 1,8'h23,2,0);     add(0,0,0, 0,8'h23,2,0);     add(0,0,1, 0,8'h23,2,0);
    add(0,0,0, 1,8'h24,1,0);     add(0,0,0, 0,8'h24,1,0);     add(0,0,1, 0,8'h24,1,0);
    add(0,0,0, 1,8'h55,0,0);     add(0,0,0, 0,8'h55,0,0);     add(0,0,1, 0,8'h55,0,0);
    add(0,0,0, 0,8'h55,0,0);
    run("fullpop");
    // done held three cycles: only the WAIT_DONE cycle counts
    add(1,8'h40,0, 0,8'h55,1,0); add(1,8'h41,0, 1,8'h40,1,0); add(1,8'h42,0, 0,8'h40,2,0);
    add(0,0,1, 0,8'h40,2,0);     add(0,0,1, 1,8'h41,1,0);     add(0,0,1, 0,8'h41,1,0);
    add(0,0,0, 0,8'h41,1,0);     add(0,0,0, 0,8'h41,1,0);     add(0,0,1, 0,8'h41,1,0);
    add(0,0,0, 1,8'h42,0,0);     add(0,0,0, 0,8'h42,0,0);     add(0,0,1, 0,8'h42,0,0);
    add(0,0,0, 0,8'h42,0,0);
    run("heldone");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
